// File: rtl/rf_write_arbiter_if.sv
// Bundle of signals between the two writeback requesters and the
// register-file write arbiter. The master side is the requesters and
// the register file; the slave side is the arbiter itself.
interface rf_write_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;
  logic [15:0] contention_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, Write_register, Write_data,
    input  pending_mask, contention_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, Write_register, Write_data,
    output pending_mask, contention_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester write arbiter for a single register-file write port.
// Each requester owns a one-entry buffer. One buffer is granted per cycle:
// same-register conflicts go to the older entry so writes land in order,
// otherwise a round-robin pointer alternates between requesters.
module rf_write_arbiter (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);

  logic        buf_valid_reg [2];
  logic [4:0]  buf_addr_reg  [2];
  logic [31:0] buf_data_reg  [2];
  logic        older1_reg;          // 1: buffer 1 holds the older entry
  logic        rr_ptr_reg;          // requester preferred on a non-conflicting tie
  logic [15:0] contention_cnt_reg;

  logic        req_valid [2];
  logic [4:0]  req_addr  [2];
  logic [31:0] req_data  [2];
  logic        grant     [2];
  logic        ready     [2];
  logic        both_valid;
  logic        same_addr;
  logic [31:0] mask_bits;

  assign req_valid[0] = bus.req0_valid;
  assign req_valid[1] = bus.req1_valid;
  assign req_addr[0]  = bus.req0_addr;
  assign req_addr[1]  = bus.req1_addr;
  assign req_data[0]  = bus.req0_data;
  assign req_data[1]  = bus.req1_data;

  assign both_valid = buf_valid_reg[0] & buf_valid_reg[1];
  assign same_addr  = (buf_addr_reg[0] == buf_addr_reg[1]);

  // Pick the single buffer that drives the write port this cycle.
  always_comb begin
    grant[0] = 1'b0;
    grant[1] = 1'b0;
    if (both_valid) begin
      grant[1] = same_addr ? older1_reg : rr_ptr_reg;
      grant[0] = ~grant[1];
    end else begin
      grant[0] = buf_valid_reg[0];
      grant[1] = buf_valid_reg[1];
    end
  end

  // A buffer can accept when empty or when it is being drained this cycle.
  assign ready[0]       = ~buf_valid_reg[0] | grant[0];
  assign ready[1]       = ~buf_valid_reg[1] | grant[1];
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  // Drive the register-file write port from the granted buffer; register 0 is never written.
  always_comb begin
    bus.RegWrite       = 1'b0;
    bus.Write_register = 5'd0;
    bus.Write_data     = 32'd0;
    if (grant[0]) begin
      bus.RegWrite       = (buf_addr_reg[0] != 5'd0);
      bus.Write_register = buf_addr_reg[0];
      bus.Write_data     = buf_data_reg[0];
    end else if (grant[1]) begin
      bus.RegWrite       = (buf_addr_reg[1] != 5'd0);
      bus.Write_register = buf_addr_reg[1];
      bus.Write_data     = buf_data_reg[1];
    end
  end

  // Pending-write mask: one bit per register with a buffered, uncommitted write.
  assign mask_bits[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_mask
      assign mask_bits[gi] = (buf_valid_reg[0] & (buf_addr_reg[0] == gi[4:0])) |
                             (buf_valid_reg[1] & (buf_addr_reg[1] == gi[4:0]));
    end
  endgenerate
  assign bus.pending_mask   = mask_bits;
  assign bus.contention_cnt = contention_cnt_reg;

  // Buffer load/drain; a load in the same edge as a drain keeps the new entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_valid_reg[i] <= 1'b0;
        buf_addr_reg[i]  <= 5'd0;
        buf_data_reg[i]  <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && ready[i]) begin
          buf_valid_reg[i] <= 1'b1;
          buf_addr_reg[i]  <= req_addr[i];
          buf_data_reg[i]  <= req_data[i];
        end else if (grant[i]) begin
          buf_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Arbitration history: age of the entries, round-robin pointer, contention counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      older1_reg         <= 1'b0;
      rr_ptr_reg         <= 1'b0;
      contention_cnt_reg <= 16'd0;
    end else begin
      if ((req_valid[0] && ready[0]) && (req_valid[1] && ready[1])) begin
        older1_reg <= 1'b0;
      end else if ((req_valid[0] && ready[0]) && buf_valid_reg[1] && !grant[1]) begin
        older1_reg <= 1'b1;
      end else if ((req_valid[1] && ready[1]) && buf_valid_reg[0] && !grant[0]) begin
        older1_reg <= 1'b0;
      end
      if (grant[0]) begin
        rr_ptr_reg <= 1'b1;
      end else if (grant[1]) begin
        rr_ptr_reg <= 1'b0;
      end
      if (both_valid && (contention_cnt_reg != 16'hFFFF)) begin
        contention_cnt_reg <= contention_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, mid-operation reset,
// long streaming run and randomized traffic against a reference model.
module tb_rf_write_arbiter;

  logic clk;
  logic reset;
  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int mis_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] mask;
    logic        r0;
    logic        r1;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                              input logic [31:0] mask, input logic r0, input logic r1,
                              input logic [15:0] cnt);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.rw = rw; v.wr = wr; v.wd = wd; v.mask = mask;
    v.r0 = r0; v.r1 = r1; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  // Reference model: each requester holds at most one entry stamped with an
  // arrival sequence number; requester 0 is stamped first in a shared cycle.
  bit          m_v   [2];
  logic [4:0]  m_a   [2];
  logic [31:0] m_d   [2];
  int unsigned m_seq [2];
  int unsigned seq_ctr;
  bit          m_rr;
  int          m_cnt;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_a[k] = 0; m_d[k] = 0; m_seq[k] = 0;
    end
    seq_ctr = 0;
    m_rr = 0;
    m_cnt = 0;
  endtask

  function automatic int m_pick();
    if (m_v[0] && m_v[1]) begin
      if (m_a[0] == m_a[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return m_rr ? 1 : 0;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  task automatic model_check(input string tag);
    int g;
    logic [31:0] mask;
    g = m_pick();
    mask = 32'd0;
    for (int k = 0; k < 2; k++)
      if (m_v[k] && m_a[k] != 5'd0) mask[m_a[k]] = 1'b1;
    chk({tag, "_rw"},   {31'd0, bus.RegWrite}, {31'd0, (g >= 0) && (m_a[g] != 5'd0)});
    chk({tag, "_wr"},   {27'd0, bus.Write_register}, (g >= 0) ? {27'd0, m_a[g]} : 32'd0);
    chk({tag, "_wd"},   bus.Write_data, (g >= 0) ? m_d[g] : 32'd0);
    chk({tag, "_mask"}, bus.pending_mask, mask);
    chk({tag, "_r0"},   {31'd0, bus.req0_ready}, {31'd0, (!m_v[0]) || (g == 0)});
    chk({tag, "_r1"},   {31'd0, bus.req1_ready}, {31'd0, (!m_v[1]) || (g == 1)});
    chk({tag, "_cnt"},  {16'd0, bus.contention_cnt}, m_cnt);
  endtask

  task automatic model_clock();
    int g;
    bit rdy [2];
    bit iv  [2];
    logic [4:0]  ia [2];
    logic [31:0] id [2];
    iv[0] = bus.req0_valid; ia[0] = bus.req0_addr; id[0] = bus.req0_data;
    iv[1] = bus.req1_valid; ia[1] = bus.req1_addr; id[1] = bus.req1_data;
    g = m_pick();
    for (int k = 0; k < 2; k++) rdy[k] = (!m_v[k]) || (g == k);
    if (m_v[0] && m_v[1] && m_cnt < 65535) m_cnt++;
    if (g >= 0) begin
      m_v[g] = 0;
      m_rr = (g == 0);
    end
    for (int k = 0; k < 2; k++) begin
      if (iv[k] && rdy[k]) begin
        m_v[k] = 1; m_a[k] = ia[k]; m_d[k] = id[k];
        m_seq[k] = seq_ctr;
        seq_ctr++;
      end
    end
  endtask

  // Hold reset for two edges, check the reset outputs, release just after an edge.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw",   {31'd0, bus.RegWrite}, 32'd0);
    chk("rst_wr",   {27'd0, bus.Write_register}, 32'd0);
    chk("rst_wd",   bus.Write_data, 32'd0);
    chk("rst_mask", bus.pending_mask, 32'd0);
    chk("rst_r0",   {31'd0, bus.req0_ready}, 32'd1);
    chk("rst_r1",   {31'd0, bus.req1_ready}, 32'd1);
    chk("rst_cnt",  {16'd0, bus.contention_cnt}, 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  vec_t tbl [17];
  logic [4:0] apool [5];

  initial begin
    int bad;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;

    // Directed vectors: inputs during cycle i, outputs expected during cycle i.
    tbl[0]  = mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0,           0, 0, 0,            32'h0,   1, 1, 0);
    tbl[1]  = mk(0, 0, 0,             0, 0, 0,           1, 5, 32'hDEAD_BEEF, 32'h20,  1, 1, 0);
    tbl[2]  = mk(0, 0, 0,             1, 0, 32'hFFFF_FFFF, 0, 0, 0,          32'h0,   1, 1, 0);
    tbl[3]  = mk(0, 0, 0,             0, 0, 0,           0, 0, 32'hFFFF_FFFF, 32'h0,   1, 1, 0);
    tbl[4]  = mk(0, 0, 0,             0, 0, 0,           0, 0, 0,            32'h0,   1, 1, 0);
    tbl[5]  = mk(1, 3, 32'h33,        1, 7, 32'h77,      0, 0, 0,            32'h0,   1, 1, 0);
    tbl[6]  = mk(0, 0, 0,             0, 0, 0,           1, 3, 32'h33,       32'h88,  1, 0, 0);
    tbl[7]  = mk(0, 0, 0,             0, 0, 0,           1, 7, 32'h77,       32'h80,  1, 1, 1);
    tbl[8]  = mk(0, 0, 0,             1, 9, 32'h1,       0, 0, 0,            32'h0,   1, 1, 1);
    tbl[9]  = mk(1, 9, 32'h2,         0, 0, 0,           1, 9, 32'h1,        32'h200, 1, 1, 1);
    tbl[10] = mk(0, 0, 0,             0, 0, 0,           1, 9, 32'h2,        32'h200, 1, 1, 1);
    tbl[11] = mk(0, 0, 0,             0, 0, 0,           0, 0, 0,            32'h0,   1, 1, 1);
    tbl[12] = mk(1, 6, 32'hA,         1, 6, 32'hB,       0, 0, 0,            32'h0,   1, 1, 1);
    tbl[13] = mk(1, 6, 32'hC,         0, 0, 0,           1, 6, 32'hA,        32'h40,  1, 0, 1);
    tbl[14] = mk(0, 0, 0,             0, 0, 0,           1, 6, 32'hB,        32'h40,  0, 1, 2);
    tbl[15] = mk(0, 0, 0,             0, 0, 0,           1, 6, 32'hC,        32'h40,  1, 1, 3);
    tbl[16] = mk(0, 0, 0,             0, 0, 0,           0, 0, 0,            32'h0,   1, 1, 3);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("t%0d_rw", i),   {31'd0, bus.RegWrite}, {31'd0, tbl[i].rw});
      chk($sformatf("t%0d_wr", i),   {27'd0, bus.Write_register}, {27'd0, tbl[i].wr});
      chk($sformatf("t%0d_wd", i),   bus.Write_data, tbl[i].wd);
      chk($sformatf("t%0d_mask", i), bus.pending_mask, tbl[i].mask);
      chk($sformatf("t%0d_r0", i),   {31'd0, bus.req0_ready}, {31'd0, tbl[i].r0});
      chk($sformatf("t%0d_r1", i),   {31'd0, bus.req1_ready}, {31'd0, tbl[i].r1});
      chk($sformatf("t%0d_cnt", i),  {16'd0, bus.contention_cnt}, {16'd0, tbl[i].cnt});
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a cycle with both buffers full.
    do_reset();
    drive(1, 1, 32'h111, 1, 2, 32'h222);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_full_mask", bus.pending_mask, 32'h6);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rw",   {31'd0, bus.RegWrite}, 32'd0);
    chk("mid_mask", bus.pending_mask, 32'd0);
    chk("mid_wr",   {27'd0, bus.Write_register}, 32'd0);
    chk("mid_r0",   {31'd0, bus.req0_ready}, 32'd1);
    chk("mid_r1",   {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    chk("rel_rw",   {31'd0, bus.RegWrite}, 32'd0);
    chk("rel_mask", bus.pending_mask, 32'd0);
    drive(1, 12, 32'h1234, 0, 0, 0);
    #1;
    chk("rel_r0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("rel_acc_rw", {31'd0, bus.RegWrite}, 32'd1);
    chk("rel_acc_wr", {27'd0, bus.Write_register}, 32'd12);
    chk("rel_acc_wd", bus.Write_data, 32'h1234);
    @(posedge clk);
    #1;
    chk("rel_after_rw", {31'd0, bus.RegWrite}, 32'd0);

    // Streaming: both requesters always valid with distinct registers.
    do_reset();
    bad = 0;
    for (int i = 0; i < 70000; i++) begin
      drive(1, 1, i, 1, 2, ~i);
      #1;
      if (i >= 1) begin
        if (bus.RegWrite !== 1'b1 || bus.Write_register !== ((i % 2 == 1) ? 5'd1 : 5'd2))
          bad++;
      end
      if (i == 1000) chk("stream_cnt_1000", {16'd0, bus.contention_cnt}, 32'd999);
      @(posedge clk);
      #1;
    end
    chk("stream_alt_bad", bad, 32'd0);
    chk("stream_cnt_sat", {16'd0, bus.contention_cnt}, 32'hFFFF);
    drive(0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    apool[0] = 5'd0; apool[1] = 5'd1; apool[2] = 5'd2; apool[3] = 5'd3; apool[4] = 5'd31;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, apool[$urandom_range(0, 4)], $urandom,
            $urandom_range(0, 9) < 6, apool[$urandom_range(0, 4)], $urandom);
      #1;
      model_check($sformatf("rnd%0d", i));
      model_clock();
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      #1;
      model_check("drain");
      model_clock();
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
